// File: rtl/jb_oran_lphy_reset_sequencer.sv
// -----------------------------------------------------------------------------
// jb_oran_lphy_reset_sequencer
//
// Sequences a reconfiguration of the O-RAN low-PHY uplink (UL) and PRACH paths.
// The register map raises a request. This block then does the following:
//   1. Waits for a symbol boundary.
//   2. Clears the selected paths and waits for them to drain, with a timeout.
//   3. Pulses their FIFO resets.
//   4. Lets the paths settle.
//   5. Issues a single cfg_commit, aligned to the next symbol boundary, which
//      loads the staged control into the live lphy control interface.
//
// Ports
//   clk                      single clock for everything
//   rst                      synchronous, active-high reset
//   req_valid / req_ready    request handshake; ready only when idle
//   req_path[1:0]            bit0 = UL, bit1 = PRACH, 2'b00 = commit only
//   sym_boundary             single-cycle symbol-start strobe
//   ul_idle / prach_idle     datapath drained indications
//   ul_lphy_oran_clear       UL clear
//   ul_lphy_oran_fifo_reset  UL FIFO reset
//   prach_oran_clear         PRACH clear
//   prach_oran_fifo_reset    PRACH FIFO reset
//   cfg_commit               one-cycle load strobe for the live control
//   busy                     sequence in progress (state not IDLE)
//   done                     one-cycle completion pulse, alongside cfg_commit
//   timeout_err              one-cycle pulse when draining timed out
// -----------------------------------------------------------------------------
module jb_oran_lphy_reset_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int SETTLE_CYCLES  = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_path,
  input  logic       sym_boundary,
  input  logic       ul_idle,
  input  logic       prach_idle,
  output logic       ul_lphy_oran_clear,
  output logic       ul_lphy_oran_fifo_reset,
  output logic       prach_oran_clear,
  output logic       prach_oran_fifo_reset,
  output logic       cfg_commit,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  // The single phase counter must reach (largest parameter - 1).
  localparam int MAX_RS     = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYCLES = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_B1     = 3'd1,
    ST_DRAIN       = 3'd2,
    ST_RESET       = 3'd3,
    ST_SETTLE      = 3'd4,
    ST_COMMIT_WAIT = 3'd5,
    ST_DONE        = 3'd6
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       path_r;
  logic             drain_ok_s;

  // Drain condition (unselected paths ignored) and state-decoded handshake flags.
  always_comb begin
    drain_ok_s = (~path_r[0] | ul_idle) & (~path_r[1] | prach_idle);
    busy       = (state_r != ST_IDLE);
    req_ready  = (state_r == ST_IDLE) & ~rst;
  end

  // Sequencer FSM with its shared phase counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r                 <= ST_IDLE;
      cnt_r                   <= CNT_ZERO;
      path_r                  <= 2'b00;
      ul_lphy_oran_clear      <= 1'b0;
      ul_lphy_oran_fifo_reset <= 1'b0;
      prach_oran_clear        <= 1'b0;
      prach_oran_fifo_reset   <= 1'b0;
      cfg_commit              <= 1'b0;
      done                    <= 1'b0;
      timeout_err             <= 1'b0;
    end else begin
      // Pulse outputs default low; the counter free-runs and is zeroed on each state entry.
      cnt_r       <= cnt_r + CNT_ONE;
      cfg_commit  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            path_r  <= req_path;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_WAIT_B1;
          end
        end
        ST_WAIT_B1: begin
          // Only strobes after the accept edge are seen here.
          if (sym_boundary) begin
            cnt_r <= CNT_ZERO;
            if (path_r != 2'b00) begin
              ul_lphy_oran_clear <= path_r[0];
              prach_oran_clear   <= path_r[1];
              state_r            <= ST_DRAIN;
            end else begin
              // Commit-only request: this boundary already serves as the commit
              // boundary, so the commit is issued immediately.
              cfg_commit <= 1'b1;
              done       <= 1'b1;
              state_r    <= ST_DONE;
            end
          end
        end
        ST_DRAIN: begin
          // When drain and timeout coincide, the drain wins and no error is flagged.
          if (drain_ok_s || (cnt_r == TIMEOUT_LAST)) begin
            timeout_err             <= ~drain_ok_s;
            ul_lphy_oran_fifo_reset <= path_r[0];
            prach_oran_fifo_reset   <= path_r[1];
            cnt_r                   <= CNT_ZERO;
            state_r                 <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (cnt_r == RST_LAST) begin
            ul_lphy_oran_clear      <= 1'b0;
            ul_lphy_oran_fifo_reset <= 1'b0;
            prach_oran_clear        <= 1'b0;
            prach_oran_fifo_reset   <= 1'b0;
            cnt_r                   <= CNT_ZERO;
            state_r                 <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_COMMIT_WAIT;
          end
        end
        ST_COMMIT_WAIT: begin
          if (sym_boundary) begin
            cfg_commit <= 1'b1;
            done       <= 1'b1;
            cnt_r      <= CNT_ZERO;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Holds off req_ready during the commit cycle, so the next accept is
          // possible at the earliest one cycle after done.
          cnt_r   <= CNT_ZERO;
          state_r <= ST_IDLE;
        end
        default: begin
          ul_lphy_oran_clear      <= 1'b0;
          ul_lphy_oran_fifo_reset <= 1'b0;
          prach_oran_clear        <= 1'b0;
          prach_oran_fifo_reset   <= 1'b0;
          cnt_r                   <= CNT_ZERO;
          state_r                 <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jb_oran_lphy_reset_sequencer.sv
// Scoreboard bench for jb_oran_lphy_reset_sequencer (RST=4, SETTLE=8, TIMEOUT=64).
//
// Conventions used by this bench:
//   - Cycle numbering: cyc counts rising edges, and the monitor samples 1 time
//     unit after each edge.
//   - Input timing: inputs are driven on falling edges, so a value driven at
//     cyc==N-1 is sampled at edge N.
//   - Scoreboard: every output edge, and every high sample of a pulse, is an
//     event {cycle, kind}. The stimulus pushes the expected events; the monitor
//     pops and compares them.
//   - Symbol boundaries: a strobe is sampled at every edge that is a multiple
//     of 100, plus one extra strobe at edge 808.
module tb_jb_oran_lphy_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_path;
  logic       sym_boundary;
  logic       ul_idle;
  logic       prach_idle;
  logic       ul_lphy_oran_clear;
  logic       ul_lphy_oran_fifo_reset;
  logic       prach_oran_clear;
  logic       prach_oran_fifo_reset;
  logic       cfg_commit;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int cyc       = 0;
  int tests     = 0;
  int fails     = 0;
  int extra_bnd = 808;

  // Event kinds: rise/fall pairs in monitor order, followed by the pulses.
  localparam int K_RDY_R = 0,  K_RDY_F = 1,  K_BSY_R = 2,  K_BSY_F = 3;
  localparam int K_ULC_R = 4,  K_ULC_F = 5,  K_ULR_R = 6,  K_ULR_F = 7;
  localparam int K_PRC_R = 8,  K_PRC_F = 9,  K_PRR_R = 10, K_PRR_F = 11;
  localparam int K_CMT   = 12, K_DONE  = 13, K_TMO   = 14;

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  exp_t exp_q[$];

  jb_oran_lphy_reset_sequencer #(
    .RST_CYCLES    (4),
    .SETTLE_CYCLES (8),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_path               (req_path),
    .sym_boundary           (sym_boundary),
    .ul_idle                (ul_idle),
    .prach_idle             (prach_idle),
    .ul_lphy_oran_clear     (ul_lphy_oran_clear),
    .ul_lphy_oran_fifo_reset(ul_lphy_oran_fifo_reset),
    .prach_oran_clear       (prach_oran_clear),
    .prach_oran_fifo_reset  (prach_oran_fifo_reset),
    .cfg_commit             (cfg_commit),
    .busy                   (busy),
    .done                   (done),
    .timeout_err            (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      0: return "ready_rise";
      1: return "ready_fall";
      2: return "busy_rise";
      3: return "busy_fall";
      4: return "ul_clear_rise";
      5: return "ul_clear_fall";
      6: return "ul_fiforst_rise";
      7: return "ul_fiforst_fall";
      8: return "prach_clear_rise";
      9: return "prach_clear_fall";
      10: return "prach_fiforst_rise";
      11: return "prach_fiforst_fall";
      12: return "cfg_commit";
      13: return "done";
      14: return "timeout_err";
      default: return "unknown";
    endcase
  endfunction

  // Insert keeping the queue ordered by (cycle, kind), which is the monitor's order.
  function automatic void push_exp(input int c, input int k);
    exp_t e;
    int   idx;
    e.cyc  = c;
    e.kind = k;
    idx    = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((exp_q[i].cyc * 16 + exp_q[i].kind) > (c * 16 + k)) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, e);
  endfunction

  task automatic check_event(input int k);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event: got %s at cycle %0d, expected no further event", kname(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.cyc != cyc)) begin
        fails++;
        $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                 kname(k), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  task automatic at_edge(input int e);
    do @(negedge clk); while (cyc < e - 1);
  endtask

  // Symbol boundary strobe generator.
  initial begin
    sym_boundary = 1'b0;
    forever begin
      @(negedge clk);
      sym_boundary = (((cyc + 1) % 100) == 0) || ((cyc + 1) == extra_bnd);
    end
  end

  // Monitor: reset-state snapshot plus event detection against the scoreboard.
  logic       rst_s;
  logic [5:0] lv;
  logic [5:0] pv;
  logic [8:0] snap;
  initial begin
    pv = 6'b0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #1;
      lv = {prach_oran_fifo_reset, prach_oran_clear, ul_lphy_oran_fifo_reset,
            ul_lphy_oran_clear, busy, req_ready};
      if (rst_s) begin
        tests++;
        snap = {lv, cfg_commit, done, timeout_err};
        if (snap !== 9'b0) begin
          fails++;
          $display("FAIL reset_state: cycle %0d outputs %b, expected %b", cyc, snap, 9'b0);
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (lv[i] && !pv[i]) check_event(2 * i);
        if (!lv[i] && pv[i]) check_event(2 * i + 1);
      end
      if (cfg_commit)  check_event(K_CMT);
      if (done)        check_event(K_DONE);
      if (timeout_err) check_event(K_TMO);
      pv = lv;
    end
  end

  // Watchdog: the stimulus below ends near cycle 1300.
  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached, expected finish by cycle 1300", cyc);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus; each block pushes its hand-derived expected events.
  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_path   = 2'b00;
    ul_idle    = 1'b0;
    prach_idle = 1'b0;

    // Reset is sampled at edges 1..3; ready appears on the first cycle after it.
    push_exp(4, K_RDY_R);
    at_edge(4);
    rst = 1'b0;

    // Scenario 1, UL only.
    // Accept at edge 10 and boundary at edge 100, so clear is high from 100.
    // ul_idle rises at 110, so fifo_reset is high for 110..113.
    // Both fall at 114; commit is issued on the boundary at 200.
    push_exp(10, K_RDY_F);  push_exp(10, K_BSY_R);
    push_exp(100, K_ULC_R); push_exp(110, K_ULR_R);
    push_exp(114, K_ULC_F); push_exp(114, K_ULR_F);
    push_exp(200, K_CMT);   push_exp(200, K_DONE);
    push_exp(201, K_BSY_F); push_exp(201, K_RDY_R);
    at_edge(10);  req_valid = 1'b1; req_path = 2'b01;
    at_edge(11);  req_valid = 1'b0;
    at_edge(110); ul_idle = 1'b1;
    at_edge(205); ul_idle = 1'b0;

    // Scenario 2, commit only: accept at 210, commit on the boundary at 300.
    push_exp(210, K_RDY_F); push_exp(210, K_BSY_R);
    push_exp(300, K_CMT);   push_exp(300, K_DONE);
    push_exp(301, K_BSY_F); push_exp(301, K_RDY_R);
    at_edge(210); req_valid = 1'b1; req_path = 2'b00;
    at_edge(211); req_valid = 1'b0;

    // Scenario 3, timeout: PRACH never drains.
    // Clears rise at 400; timeout and both fifo resets occur at 400+64 = 464.
    // Everything falls at 468; commit is issued at 500.
    push_exp(310, K_RDY_F); push_exp(310, K_BSY_R);
    push_exp(400, K_ULC_R); push_exp(400, K_PRC_R);
    push_exp(464, K_ULR_R); push_exp(464, K_PRR_R); push_exp(464, K_TMO);
    push_exp(468, K_ULC_F); push_exp(468, K_ULR_F);
    push_exp(468, K_PRC_F); push_exp(468, K_PRR_F);
    push_exp(500, K_CMT);   push_exp(500, K_DONE);
    push_exp(501, K_BSY_F); push_exp(501, K_RDY_R);
    at_edge(305); ul_idle = 1'b1; prach_idle = 1'b0;
    at_edge(310); req_valid = 1'b1; req_path = 2'b11;
    at_edge(311); req_valid = 1'b0;

    // Scenario 4, back-pressure: req_valid is held high, PRACH path, already idle.
    // First request: clear at 600, fifo reset at 601, both fall at 605, done at 700.
    // Ready returns at 701 and the second accept happens at 702.
    // Second request: an extra strobe at 808 falls in SETTLE (806..813) and is
    // ignored, so the commit waits for the boundary at 900.
    push_exp(510, K_RDY_F); push_exp(510, K_BSY_R);
    push_exp(600, K_PRC_R); push_exp(601, K_PRR_R);
    push_exp(605, K_PRC_F); push_exp(605, K_PRR_F);
    push_exp(700, K_CMT);   push_exp(700, K_DONE);
    push_exp(701, K_RDY_R); push_exp(701, K_BSY_F);
    push_exp(702, K_RDY_F); push_exp(702, K_BSY_R);
    push_exp(800, K_PRC_R); push_exp(801, K_PRR_R);
    push_exp(805, K_PRC_F); push_exp(805, K_PRR_F);
    push_exp(900, K_CMT);   push_exp(900, K_DONE);
    push_exp(901, K_BSY_F); push_exp(901, K_RDY_R);
    at_edge(505); ul_idle = 1'b0; prach_idle = 1'b1;
    at_edge(510); req_valid = 1'b1; req_path = 2'b10;
    at_edge(703); req_valid = 1'b0;
    at_edge(905); prach_idle = 1'b0;

    // Scenario 5, accept coincides with the boundary at 1000.
    // That strobe is ignored, so the commit is issued at 1100.
    push_exp(1000, K_RDY_F); push_exp(1000, K_BSY_R);
    push_exp(1100, K_CMT);   push_exp(1100, K_DONE);
    push_exp(1101, K_BSY_F); push_exp(1101, K_RDY_R);
    at_edge(1000); req_valid = 1'b1; req_path = 2'b00;
    at_edge(1001); req_valid = 1'b0;

    // Scenario 6, reset pulse while in RESET.
    // Clear at 1200 and fifo reset at 1201; rst is sampled at 1203.
    // All outputs drop at 1203 with no done; ready returns at 1204.
    push_exp(1110, K_RDY_F); push_exp(1110, K_BSY_R);
    push_exp(1200, K_ULC_R); push_exp(1201, K_ULR_R);
    push_exp(1203, K_BSY_F); push_exp(1203, K_ULC_F); push_exp(1203, K_ULR_F);
    push_exp(1204, K_RDY_R);
    at_edge(1105); ul_idle = 1'b1;
    at_edge(1110); req_valid = 1'b1; req_path = 2'b01;
    at_edge(1111); req_valid = 1'b0;
    at_edge(1203); rst = 1'b1;
    at_edge(1204); rst = 1'b0;

    // Idle past another boundary (1300); then every expected event must have been seen.
    at_edge(1305);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d expected events not seen, first is %s at cycle %0d, required 0 left",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
